// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus fetch stage.
//   fetch_entry_t : {pc, instr} payload buffered between memory and decode
//   KAMUS_PC_W    : width of the pc field carried in fetch_entry_t
//   INSTR_BYTES   : PC increment per fetched word
package kamus_pkg;

  localparam int unsigned KAMUS_PC_W  = 32;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [KAMUS_PC_W-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [KAMUS_PC_W-1:0] pc;
    logic [INSTR_W-1:0]    instr;
  } fetch_entry_t;

endpackage

// File: rtl/kamus_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t between instruction memory and decode.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : empties the FIFO; wins over a same-cycle push
//   push_i/wdata_i, pop_i : write and read strobes (pop ignored when empty)
//   rdata_o      : head entry (undefined while empty)
//   count_o, full_o, empty_o : occupancy
module kamus_fetch_fifo
  import kamus_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           wdata_i,
  input  logic                   pop_i,
  output fetch_entry_t           rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;
  assign rdata_o = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array, no reset needed: contents are only read when count > 0.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !do_pop && !flush_i));

endmodule

// File: rtl/kamus_instr_fetch.sv
// Fetch stage: owns the PC, requests words from instruction memory, buffers
// in-order responses and hands {instr, pc} to decode over valid/ready.
// A redirect flushes buffered words and discards responses still in flight.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   imem_req_o/addr_o/gnt_i      : request channel (word-aligned address)
//   imem_rvalid_i/rdata_i        : in-order response channel
//   redirect_i/redirect_pc_i     : flush and restart at redirect_pc_i & ~3
//   instr_valid_o/ready_i        : handshake toward decode
//   instr_o/pc_o                 : head instruction and its address (0 when empty)
// PC_WIDTH must not exceed KAMUS_PC_W (width of the buffered pc field).
module kamus_instr_fetch
  import kamus_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = KAMUS_PC_W,
  parameter logic [PC_WIDTH-1:0]  BOOT_ADDR = PC_WIDTH'(BOOT_ADDR_DEFAULT),
  parameter int unsigned          DEPTH     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [31:0]         imem_rdata_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       outstanding_nxt;
  logic [CW-1:0]       discard;

  // Addresses of granted requests, consumed in order as responses return.
  logic [PC_WIDTH-1:0] pc_ring [DEPTH];
  logic [AW-1:0]       ring_wr;
  logic [AW-1:0]       ring_rd;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  fetch_entry_t        fifo_wdata;
  fetch_entry_t        fifo_head;

  logic                has_room;
  logic                grant;
  logic                resp;
  logic                push;
  logic                pop;

  // Every buffered or in-flight word holds a FIFO slot, so a grant can never overflow it.
  always_comb begin
    has_room   = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
    imem_req_o = !rst_i && !redirect_i && has_room;
    grant      = imem_req_o && imem_gnt_i;
    resp       = imem_rvalid_i && (outstanding != '0);
    push       = resp && (discard == '0);
    pop        = instr_valid_o && instr_ready_i;
    outstanding_nxt = outstanding + CW'(grant) - CW'(resp);
  end

  assign imem_addr_o = fetch_pc;

  // PC, in-flight count and discard count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        fetch_pc <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        discard  <= outstanding_nxt;
      end else begin
        if (grant) fetch_pc <= fetch_pc + PC_WIDTH'(INSTR_BYTES);
        if (resp && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  // Request-address ring; survives redirects so discarded responses still retire their slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ring_wr <= '0;
      ring_rd <= '0;
    end else begin
      if (grant) ring_wr <= ring_wr + AW'(1);
      if (resp)  ring_rd <= ring_rd + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) pc_ring[ring_wr] <= fetch_pc;
  end

  always_comb begin
    fifo_wdata       = '0;
    fifo_wdata.pc    = KAMUS_PC_W'(pc_ring[ring_rd]);
    fifo_wdata.instr = imem_rdata_i;
  end

  kamus_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Decode sees the FIFO head directly; data forced to zero while empty.
  always_comb begin
    instr_valid_o = !fifo_empty;
    instr_o       = fifo_empty ? '0 : fifo_head.instr;
    pc_o          = fifo_empty ? '0 : PC_WIDTH'(fifo_head.pc);
  end

  a_addr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_addr_o[1:0] == 2'b00);
  a_discard_le_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    discard <= outstanding);
  a_outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full && !pop && !redirect_i));

endmodule
